modn_counter: RTL

Parametrised modulo-N counter that generalises the fixed mod-5 counter used in the timing and sequencing logic. Counts 0..max_val up or down, with a runtime-programmable terminal value, count enable, synchronous load, a registered wrap pulse for cascading, and a one-shot mode that halts at the terminal value. Sits wherever the design needs a divide-by-N tick, a sequence index or a bounded event count.

---
 rtl/modn_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/modn_counter.sv
// Modulo-N up/down counter with runtime terminal value, synchronous load,
// registered wrap/halt pulse for cascading and an optional one-shot halt.
module modn_counter #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned MAX_DEFAULT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_max,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done,
    output logic [WIDTH-1:0] max_val
);

    localparam logic [WIDTH-1:0] MaxReset = WIDTH'(MAX_DEFAULT);

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic             step_en;
    logic             above_max;
    logic             at_top;
    logic             at_bottom;
    logic             terminal;

    // A step only happens while running, enabled and not overridden by load.
    assign step_en   = (state_q == StRun) && en && !load;
    assign above_max = out_q > max_q;
    assign at_top    = out_q >= max_q;
    assign at_bottom = out_q == '0;
    // Down-count above max_val is a clamp, never a terminal event.
    assign terminal  = up ? at_top : (at_bottom && !above_max);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StRun;
        end else if (step_en && terminal && oneshot) begin
            state_d = StHalt;
        end
    end

    // Datapath next-state logic; all decisions use the pre-edge max_q.
    always_comb begin
        out_d  = out_q;
        tc_d   = 1'b0;
        done_d = done_q;
        max_d  = cfg_we ? cfg_max : max_q;

        if (load) begin
            out_d  = (load_val > max_q) ? max_q : load_val;
            done_d = 1'b0;
        end else if (step_en) begin
            if (up) begin
                if (!at_top) begin
                    out_d = out_q + WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
                    if (oneshot) begin
                        done_d = 1'b1;
                    end else begin
                        out_d = '0;
                    end
                end
            end else begin
                if (above_max) begin
                    out_d = max_q;
                end else if (!at_bottom) begin
                    out_d = out_q - WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
                    if (oneshot) begin
                        done_d = 1'b1;
                    end else begin
                        out_d = max_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q  <= '0;
            tc_q   <= 1'b0;
            done_q <= 1'b0;
            max_q  <= MaxReset;
        end else begin
            out_q  <= out_d;
            tc_q   <= tc_d;
            done_q <= done_d;
            max_q  <= max_d;
        end
    end

    assign out     = out_q;
    assign tc      = tc_q;
    assign done    = done_q;
    assign max_val = max_q;

endmodule
